// File: rtl/pq_rr_multi_if.sv
// pq_rr_multi_if: request/grant bundle between requesters and the round-robin multi-grant arbiter.
interface pq_rr_multi_if #(parameter int WIDTH = 8, parameter int ACK_COUNT = 2);
   localparam int IW = $clog2(WIDTH);
   logic [WIDTH-1:0] req_vec;
   logic ack_ready;
   logic [ACK_COUNT-1:0] ack_valid_by_port;
   logic [ACK_COUNT-1:0][WIDTH-1:0] ack_one_hot_by_port;
   logic [ACK_COUNT-1:0][IW-1:0] ack_index_by_port;
   logic [WIDTH-1:0] ack_mask;
   logic [WIDTH-1:0] unacked_req_vec;
   logic [IW-1:0] rr_ptr;
   modport master (
      output req_vec, ack_ready,
      input ack_valid_by_port, ack_one_hot_by_port, ack_index_by_port, ack_mask, unacked_req_vec, rr_ptr
   );
   modport slave (
      input req_vec, ack_ready,
      output ack_valid_by_port, ack_one_hot_by_port, ack_index_by_port, ack_mask, unacked_req_vec, rr_ptr
   );
endinterface

// File: rtl/pq_rr_multi.sv
// pq_rr_multi: round-robin arbiter granting up to ACK_COUNT requesters per cycle from a registered start pointer.
module pq_rr_multi #(
   parameter int WIDTH = 8,
   parameter int ACK_COUNT = 2
) (
   input logic clk,
   input logic rst_n,
   pq_rr_multi_if.slave bus
);
   localparam int IW = $clog2(WIDTH);
   localparam int CW = $clog2(ACK_COUNT + 1);
   logic [IW-1:0] ptr;
   logic [IW-1:0] last;
   logic [IW-1:0] pos;
   logic [IW:0] sum;
   logic [CW-1:0] cnt;
   logic [ACK_COUNT-1:0] valid;
   logic [ACK_COUNT-1:0][WIDTH-1:0] one_hot;
   logic [ACK_COUNT-1:0][IW-1:0] index;
   logic [WIDTH-1:0] mask;
   // walk positions in circular order from ptr; each hit fills the next free port
   always_comb begin
      valid = '0;
      one_hot = '0;
      index = '0;
      mask = '0;
      cnt = '0;
      last = '0;
      sum = '0;
      pos = '0;
      for (int k = 0; k < WIDTH; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         pos = IW'(sum >= (IW+1)'(WIDTH) ? sum - (IW+1)'(WIDTH) : sum);
         if (bus.req_vec[pos] && cnt < CW'(ACK_COUNT)) begin
            for (int p = 0; p < ACK_COUNT; p++)
               if (cnt == CW'(p)) begin
                  valid[p] = 1'b1;
                  one_hot[p][pos] = 1'b1;
                  index[p] = pos;
               end
            mask[pos] = 1'b1;
            last = pos;
            cnt = cnt + CW'(1);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else if (bus.ack_ready && valid[0]) ptr <= (last == IW'(WIDTH - 1)) ? '0 : last + IW'(1);
   assign bus.ack_valid_by_port = valid;
   assign bus.ack_one_hot_by_port = one_hot;
   assign bus.ack_index_by_port = index;
   assign bus.ack_mask = mask;
   assign bus.unacked_req_vec = bus.req_vec & ~mask;
   assign bus.rr_ptr = ptr;
endmodule

// File: doc/pq_rr_multi.md
Name: pq_rr_multi

Overview:
Parametrised round-robin multi-grant priority arbiter; the sequential successor to the combinational LSB priority encoder.
- Grants up to ACK_COUNT requesters per cycle, taken in circular order starting at a registered round-robin pointer.
- The pointer advances past the last accepted grant, which gives fairness across cycles.
- Used for issue-queue and writeback-port arbitration where several requests win per cycle.

Parameters:
WIDTH, 8, number of requesters; must be >= 2; need not be a power of two.
ACK_COUNT, 2, number of grant ports per cycle; must satisfy 1 <= ACK_COUNT <= WIDTH.

Ports:
CLK  input  1  clock, rising-edge.
nRST  input  1  reset, asynchronous, active-low.
req_vec  input  WIDTH  request bit per requester.
ack_ready  input  1  downstream accepts this cycle's grants; pointer updates only when high.
ack_valid_by_port  output  ACK_COUNT  port p holds a valid grant.
ack_one_hot_by_port  output  ACK_COUNT x WIDTH  one-hot grant per port; all zero if port invalid.
ack_index_by_port  output  ACK_COUNT x clog2(WIDTH)  granted index per port; 0 if port invalid.
ack_mask  output  WIDTH  OR of all ack_one_hot_by_port.
unacked_req_vec  output  WIDTH  req_vec & ~ack_mask.
rr_ptr  output  clog2(WIDTH)  current registered round-robin start index (debug/verification).

Behaviour:
- State: rr_ptr register only. All grant outputs are combinational functions of req_vec and rr_ptr; there is no grant latency.
- Search order: positions (rr_ptr + k) mod WIDTH for k = 0..WIDTH-1.
  - Modulo is true mod WIDTH; there is no power-of-two wrap assumption.
- Grant assignment: port p grants the (p+1)-th set bit of req_vec in search order.
  - ack_valid_by_port[p] = (popcount(req_vec) > p).
  - Grants are distinct; valid ports are contiguous from port 0.
- Invalid port: one-hot = 0, index = 0.
- req_vec = 0: all outputs zero.
- Pointer update at posedge CLK when ack_ready & ack_valid_by_port[0]:
  - L = index of highest-numbered valid port.
  - rr_ptr <= (ack_index_by_port[L] + 1) mod WIDTH.
  - Granted index WIDTH-1 wraps rr_ptr to 0.
- Pointer hold: rr_ptr holds when ack_ready = 0 or when no port is valid.
- Consistency: ack_ready has no effect on the current-cycle grant outputs.
- Reset:
  - nRST low clears rr_ptr to 0 immediately (asynchronous) and holds it at 0 while low.
  - Outputs then reflect req_vec with rr_ptr = 0. With ACK_COUNT = 1, port 0 equals a plain LSB priority encoder.
  - Reset asserted mid-operation aborts any pending pointer update.
  - The first edge after nRST rises may update rr_ptr normally.
- ACK_COUNT = WIDTH with all requests set: every requester is granted, ack_mask all ones, unacked_req_vec zero. rr_ptr then becomes (index granted on port WIDTH-1) + 1 mod WIDTH, i.e. it returns to its own value.
- Invariants, checked every cycle:
  - ack_mask ⊆ req_vec.
  - popcount(ack_mask) = min(popcount(req_vec), ACK_COUNT).
  - No two valid ports share an index.

Test Plan:
(All scenarios use WIDTH=8, ACK_COUNT=2.)
- Reset: nRST=0, req_vec=00000000 -> all outputs 0, rr_ptr=0. Release nRST with req_vec=0, one edge -> rr_ptr stays 0.
- Basic grant with update: rr_ptr=0, req_vec=00100110, ack_ready=1 -> port0 idx1, port1 idx2, ack_mask=00000110, unacked_req_vec=00100000. Next cycle rr_ptr=3.
- Wrap-around grant: rr_ptr=3, req_vec=00100110, ack_ready=1 -> port0 idx5, port1 idx1, ack_mask=00100010. Next rr_ptr=2.
- Backpressure and single request:
  - ack_ready=0 for 3 cycles at rr_ptr=2 -> rr_ptr stays 2, grants unchanged.
  - Then req_vec=10000000, ack_ready=1 -> port0 idx7, port1 invalid. rr_ptr wraps to 0.
- Async reset mid-operation: rr_ptr=5, drop nRST between clock edges -> rr_ptr=0 before the next edge. With req_vec=00110000: port0 idx4, port1 idx5.
- Exhaustive sweep: all 256 req_vec values × all 8 rr_ptr values, ack_ready random -> outputs and next rr_ptr match the behavioural model. All invariants hold every cycle.
